decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Decode stage; consumes fetch outputs (PC, IR, valid), reads register file, issues to execute.
//  Per-register in-flight-writer scoreboard drives the dependency stall back to fetch.
//  Branch/jump FSM drives the branch stall until memory resolves the target.
//  Owns the architectural register file, written from the writeback port.
// PARAMETERS
//  NUM_REGS      16  architectural registers (index width = log2(NUM_REGS) = 4)
//  DATA_WIDTH    16  register/operand width
//  PC_WIDTH      16  PC width
//  IR_WIDTH      32  instruction width
//  SB_CNT_WIDTH  2   per-register in-flight writer counter width (max 3)
// PORTS
//  I_CLOCK             in   1   single clock; all state updates on falling edge
//  I_LOCK              in   1   synchronous active-low reset (0 = reset), sampled at falling edge
//  I_PC                in   16  PC from fetch
//  I_IR                in   32  instruction from fetch
//  I_FE_Valid          in   1   fetch slot holds a real instruction
//  I_GPUStallSignal    in   1   freeze whole stage
//  I_BranchAddrSelect  in   1   memory stage: branch target resolved
//  I_WBEnable          in   1   writeback strobe
//  I_WBRegIdx          in   4   writeback register index
//  I_WBData            in   16  writeback data
//  O_LOCK              out  1   I_LOCK delayed one edge, to execute
//  O_PC, O_Opcode      out  16, 8  issued PC / opcode (IR[31:24])
//  O_DestRegIdx        out  4   IR[23:20]
//  O_Src1Value         out  16  RF[IR[19:16]] (bypassed)
//  O_Src2Value         out  16  RF[IR[15:12]] for reg-reg, else IR[15:0]
//  O_DE_Valid          out  1   issued slot is real
//  O_DepStallSignal    out  1   combinational; fetch holds PC/IR
//  O_BranchStallSignal out  1   registered; fetch squashes until resolution
// BEHAVIOUR
//  Reset (I_LOCK=0 at edge): O_PC=0, O_Opcode=8'hFF, other data outs 0, O_DE_Valid=0,
//   O_BranchStallSignal=0, all RF entries and counters 0, FSM=RUN. O_LOCK<=I_LOCK every edge.
//   Reset mid-branch or mid-stall discards all in-flight state.
//  Class from opcode via package table: ALU_RR, ALU_RI, LOAD, STORE, BRANCH, JUMP, BUBBLE(8'hFF).
//   Writes-dest: ALU_RR, ALU_RI, LOAD. Uses SR2: ALU_RR, STORE. Unknown opcode = BUBBLE.
//  Hazard on source s: cnt[s]!=0, except cnt[s]==1 && I_WBEnable && I_WBRegIdx==s -> bypass I_WBData.
//   Writer issue also hazards if cnt[dest]==max (saturation guard).
//  O_DepStallSignal = I_FE_Valid && FSM==RUN && any hazard; combinational, same-edge for fetch.
//  Issue = I_FE_Valid && FSM==RUN && !dep stall && !GPU stall && class!=BUBBLE.
//   Issue: outputs load decoded fields, O_DE_Valid=1; writer increments cnt[dest].
//   No issue, no GPU stall: O_DE_Valid=0, O_Opcode=8'hFF (bubble), other outputs don't-care.
//  Counter: WB on reg r decrements cnt[r] (never below 0); issue+WB same reg same edge -> unchanged.
//  RF write on WB edge; same-edge read returns new data (write-through).
//  GPU stall: all outputs, FSM, counters hold; RF writes and counter decrements still occur.
//  FSM RUN: issue of BRANCH/JUMP -> BR_WAIT, O_BranchStallSignal=1 from that edge.
//   BR_WAIT: no issue, bubbles out; I_BranchAddrSelect=1 -> RUN, stall=0 next edge.
//   I_BranchAddrSelect in RUN ignored. Latency: issue 1 edge after fetch presents valid IR.
// STRUCTURE
//  decode_pkg: IR field positions, opcode constants, class enum, BUBBLE_OPCODE=8'hFF, class table.
//  Sub-module decode_scoreboard: counter array, inc/dec, hazard + bypass-select outputs.
//  Top: RF array, field decode, FSM, output registers.
// TESTING
//  Reset: I_LOCK=0 two edges -> O_DE_Valid=0, O_Opcode=FF, stalls 0, RF[5]=0; O_LOCK lags by 1.
//  RAW: ADD r3<-r1,r2 then ADD r4<-r3,r1 -> dep stall until WB r3=0x0042; second issues Src1=0x0042
//   on the WB edge (bypass), zero extra bubbles.
//  WB-only: WB r7=0x1234, then ALU_RI read r7 -> O_Src1Value=0x1234, imm in O_Src2Value.
//  Branch: BRANCH at PC 0x20 -> O_BranchStallSignal=1 next edge, bubbles until I_BranchAddrSelect,
//   stall drops next edge; later IR issues normally.
//  Saturation: 3 writes to r2 without WB -> 4th stalls; one WB r2 -> 4th issues, cnt stays 3.
//  GPU stall 3 edges mid-stream -> outputs frozen; concurrent WB r9 visible after release.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared widths, IR field positions, opcode map, instruction
//                class table and FSM state type for the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam int NUM_REGS      = 16;
    localparam int REG_IDX_WIDTH = $clog2(NUM_REGS);
    localparam int DATA_WIDTH    = 16;
    localparam int PC_WIDTH      = 16;
    localparam int IR_WIDTH      = 32;
    localparam int OPCODE_WIDTH  = 8;
    localparam int SB_CNT_WIDTH  = 2;

    localparam logic [SB_CNT_WIDTH-1:0] SB_CNT_MAX = {SB_CNT_WIDTH{1'b1}};
    localparam logic [SB_CNT_WIDTH-1:0] SB_CNT_ONE = SB_CNT_WIDTH'(1);

    // IR field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 24;
    localparam int DEST_MSB   = 23;
    localparam int DEST_LSB   = 20;
    localparam int SRC1_MSB   = 19;
    localparam int SRC1_LSB   = 16;
    localparam int SRC2_MSB   = 15;
    localparam int SRC2_LSB   = 12;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Opcode map
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD        = 8'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB        = 8'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND        = 8'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_OR         = 8'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI       = 8'h11;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI       = 8'h12;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW        = 8'h21;
    localparam logic [OPCODE_WIDTH-1:0] OP_STW        = 8'h31;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRZ        = 8'h41;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP        = 8'h51;
    localparam logic [OPCODE_WIDTH-1:0] BUBBLE_OPCODE = 8'hFF;

    typedef enum logic [2:0] {
        CLS_BUBBLE = 3'd0,
        CLS_ALU_RR = 3'd1,
        CLS_ALU_RI = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JUMP   = 3'd6
    } instr_class_e;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } fsm_state_e;

    // Opcode -> class; anything not in the map decodes as a bubble
    function automatic instr_class_e op_class(input logic [OPCODE_WIDTH-1:0] op);
        instr_class_e cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_ALU_RR;
            OP_ADDI, OP_MOVI:              cls = CLS_ALU_RI;
            OP_LDW:                        cls = CLS_LOAD;
            OP_STW:                        cls = CLS_STORE;
            OP_BRZ:                        cls = CLS_BRANCH;
            OP_JMP:                        cls = CLS_JUMP;
            default:                       cls = CLS_BUBBLE;
        endcase
        return cls;
    endfunction

    function automatic logic cls_writes_dest(input instr_class_e cls);
        return (cls == CLS_ALU_RR) || (cls == CLS_ALU_RI) || (cls == CLS_LOAD);
    endfunction

    // Every real instruction reads its SR1 field (base, operand or condition)
    function automatic logic cls_uses_src1(input instr_class_e cls);
        return (cls != CLS_BUBBLE);
    endfunction

    function automatic logic cls_uses_src2(input instr_class_e cls);
        return (cls == CLS_ALU_RR) || (cls == CLS_STORE);
    endfunction

    function automatic logic cls_is_ctrl(input instr_class_e cls);
        return (cls == CLS_BRANCH) || (cls == CLS_JUMP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_if
//  Description : Fetch, writeback and execute-side signals of the decode stage.
//                master = environment (fetch/memory/writeback/execute),
//                slave  = decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if;
    import decode_pkg::*;

    logic [PC_WIDTH-1:0]      I_PC;
    logic [IR_WIDTH-1:0]      I_IR;
    logic                     I_FE_Valid;
    logic                     I_GPUStallSignal;
    logic                     I_BranchAddrSelect;
    logic                     I_WBEnable;
    logic [REG_IDX_WIDTH-1:0] I_WBRegIdx;
    logic [DATA_WIDTH-1:0]    I_WBData;

    logic                     O_LOCK;
    logic [PC_WIDTH-1:0]      O_PC;
    logic [OPCODE_WIDTH-1:0]  O_Opcode;
    logic [REG_IDX_WIDTH-1:0] O_DestRegIdx;
    logic [DATA_WIDTH-1:0]    O_Src1Value;
    logic [DATA_WIDTH-1:0]    O_Src2Value;
    logic                     O_DE_Valid;
    logic                     O_DepStallSignal;
    logic                     O_BranchStallSignal;

    modport master (
        output I_PC, I_IR, I_FE_Valid, I_GPUStallSignal, I_BranchAddrSelect,
               I_WBEnable, I_WBRegIdx, I_WBData,
        input  O_LOCK, O_PC, O_Opcode, O_DestRegIdx, O_Src1Value, O_Src2Value,
               O_DE_Valid, O_DepStallSignal, O_BranchStallSignal
    );

    modport slave (
        input  I_PC, I_IR, I_FE_Valid, I_GPUStallSignal, I_BranchAddrSelect,
               I_WBEnable, I_WBRegIdx, I_WBData,
        output O_LOCK, O_PC, O_Opcode, O_DestRegIdx, O_Src1Value, O_Src2Value,
               O_DE_Valid, O_DepStallSignal, O_BranchStallSignal
    );

endinterface
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : decode_scoreboard
//  Description : Per-register in-flight writer counters. Produces the RAW /
//                saturation hazard for the instruction in the fetch slot and
//                the writeback bypass selects for both source operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_scoreboard
    import decode_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REG_IDX_WIDTH-1:0] src1_idx,
    input  logic [REG_IDX_WIDTH-1:0] src2_idx,
    input  logic [REG_IDX_WIDTH-1:0] dest_idx,
    input  logic                     use_src1,
    input  logic                     use_src2,
    input  logic                     writes_dest,
    input  logic                     issue,
    input  logic                     wb_en,
    input  logic [REG_IDX_WIDTH-1:0] wb_idx,
    output logic                     hazard,
    output logic                     byp_src1,
    output logic                     byp_src2
);

    logic [SB_CNT_WIDTH-1:0] cnt [NUM_REGS];
    logic [NUM_REGS-1:0]     inc_sel;
    logic [NUM_REGS-1:0]     wb_sel;
    logic                    haz_src1;
    logic                    haz_src2;
    logic                    haz_sat;

    // A source is ready when idle, or when its only outstanding writer
    // retires this very edge (then the writeback data is forwarded).
    // The saturation guard looks at the counter before the edge, so a
    // full destination stalls even while one of its writers retires.
    always_comb begin
        byp_src1 = wb_en && (wb_idx == src1_idx);
        byp_src2 = wb_en && (wb_idx == src2_idx);
        haz_src1 = use_src1 && (cnt[src1_idx] != '0)
                   && !((cnt[src1_idx] == SB_CNT_ONE) && byp_src1);
        haz_src2 = use_src2 && (cnt[src2_idx] != '0)
                   && !((cnt[src2_idx] == SB_CNT_ONE) && byp_src2);
        haz_sat  = writes_dest && (cnt[dest_idx] == SB_CNT_MAX);
        hazard   = haz_src1 || haz_src2 || haz_sat;
    end

    // One-hot increment / decrement selects per register
    always_comb begin
        inc_sel = '0;
        wb_sel  = '0;
        if (issue && writes_dest) begin
            inc_sel[dest_idx] = 1'b1;
        end
        if (wb_en) begin
            wb_sel[wb_idx] = 1'b1;
        end
    end

    // Counter update: issue increments, writeback decrements (floored at 0),
    // both on the same register cancel out
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_sel[r] && !wb_sel[r]) begin
                    cnt[r] <= cnt[r] + SB_CNT_ONE;
                end else if (!inc_sel[r] && wb_sel[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - SB_CNT_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Decode stage. Decodes the fetch slot, reads the register
//                file (with writeback forwarding), checks the scoreboard,
//                issues to execute and holds fetch during branch resolution.
//                All state changes on the falling edge of I_CLOCK.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
(
    input  logic          I_CLOCK,
    input  logic          I_LOCK,
    decode_stage_if.slave bus
);

    logic [DATA_WIDTH-1:0]    reg_file [NUM_REGS];
    logic [OPCODE_WIDTH-1:0]  opcode;
    logic [REG_IDX_WIDTH-1:0] dest_idx;
    logic [REG_IDX_WIDTH-1:0] src1_idx;
    logic [REG_IDX_WIDTH-1:0] src2_idx;
    logic [DATA_WIDTH-1:0]    imm;
    instr_class_e             instr_class;
    logic                     writes_dest;
    logic                     use_src2;
    logic                     hazard;
    logic                     byp_src1;
    logic                     byp_src2;
    logic                     fsm_run;
    logic                     issue;
    logic [DATA_WIDTH-1:0]    src1_value;
    logic [DATA_WIDTH-1:0]    src2_value;
    fsm_state_e               state;
    fsm_state_e               state_next;

    assign opcode      = bus.I_IR[OPCODE_MSB:OPCODE_LSB];
    assign dest_idx    = bus.I_IR[DEST_MSB:DEST_LSB];
    assign src1_idx    = bus.I_IR[SRC1_MSB:SRC1_LSB];
    assign src2_idx    = bus.I_IR[SRC2_MSB:SRC2_LSB];
    assign imm         = bus.I_IR[IMM_MSB:IMM_LSB];
    assign instr_class = op_class(opcode);
    assign writes_dest = cls_writes_dest(instr_class);
    assign use_src2    = cls_uses_src2(instr_class);
    assign fsm_run     = (state == ST_RUN);

    // Fetch must see the dependency stall in the same cycle, so it is not registered
    assign bus.O_DepStallSignal    = bus.I_FE_Valid && fsm_run && hazard;
    assign bus.O_BranchStallSignal = (state == ST_BR_WAIT);

    assign issue = bus.I_FE_Valid && fsm_run && !hazard && !bus.I_GPUStallSignal
                   && (instr_class != CLS_BUBBLE);

    // Write-through: a writeback to the register being read wins over the array
    assign src1_value = byp_src1 ? bus.I_WBData : reg_file[src1_idx];
    assign src2_value = !use_src2 ? imm
                      : (byp_src2 ? bus.I_WBData : reg_file[src2_idx]);

    decode_scoreboard u_scoreboard (
        .clk         (I_CLOCK),
        .rst_n       (I_LOCK),
        .src1_idx    (src1_idx),
        .src2_idx    (src2_idx),
        .dest_idx    (dest_idx),
        .use_src1    (cls_uses_src1(instr_class)),
        .use_src2    (use_src2),
        .writes_dest (writes_dest),
        .issue       (issue),
        .wb_en       (bus.I_WBEnable),
        .wb_idx      (bus.I_WBRegIdx),
        .hazard      (hazard),
        .byp_src1    (byp_src1),
        .byp_src2    (byp_src2)
    );

    // Register file: cleared on reset, written by writeback even while frozen
    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                reg_file[r] <= '0;
            end
        end else if (bus.I_WBEnable) begin
            reg_file[bus.I_WBRegIdx] <= bus.I_WBData;
        end
    end

    // Branch FSM state register
    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Branch FSM next state: enter wait on a control-transfer issue, leave on resolution
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (issue && cls_is_ctrl(instr_class)) begin
                    state_next = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                if (!bus.I_GPUStallSignal && bus.I_BranchAddrSelect) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Lock forwarded to execute one edge late, independent of reset
    always_ff @(negedge I_CLOCK) begin
        bus.O_LOCK <= I_LOCK;
    end

    // Issue registers: load on issue, bubble otherwise, hold while frozen
    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            bus.O_PC         <= '0;
            bus.O_Opcode     <= BUBBLE_OPCODE;
            bus.O_DestRegIdx <= '0;
            bus.O_Src1Value  <= '0;
            bus.O_Src2Value  <= '0;
            bus.O_DE_Valid   <= 1'b0;
        end else if (!bus.I_GPUStallSignal) begin
            if (issue) begin
                bus.O_PC         <= bus.I_PC;
                bus.O_Opcode     <= opcode;
                bus.O_DestRegIdx <= dest_idx;
                bus.O_Src1Value  <= src1_value;
                bus.O_Src2Value  <= src2_value;
                bus.O_DE_Valid   <= 1'b1;
            end else begin
                bus.O_Opcode     <= BUBBLE_OPCODE;
                bus.O_DE_Valid   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage: directed scenarios
//                followed by random traffic, compared against a cycle-level
//                behavioural model of the decode rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic clk;
    logic lock;

    decode_stage_if bus ();

    decode_stage dut (
        .I_CLOCK (clk),
        .I_LOCK  (lock),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int m_rf  [16];
    int m_cnt [16];
    bit m_wait;
    bit e_valid, e_bstall, e_lock, e_reset;
    int e_op, e_pc, e_dest, e_s1, e_s2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 bubble, 1 reg-reg ALU, 2 reg-imm ALU, 3 load, 4 store, 5 branch, 6 jump
    function automatic int cls_of(input logic [7:0] op);
        case (op)
            8'h01, 8'h02, 8'h03, 8'h04: return 1;
            8'h11, 8'h12:               return 2;
            8'h21:                      return 3;
            8'h31:                      return 4;
            8'h41:                      return 5;
            8'h51:                      return 6;
            default:                    return 0;
        endcase
    endfunction

    function automatic bit busy(input int s);
        bit retiring;
        retiring = bus.I_WBEnable && (int'(bus.I_WBRegIdx) == s);
        return (m_cnt[s] > 0) && !((m_cnt[s] == 1) && retiring);
    endfunction

    // Expected dependency stall for the inputs currently presented
    function automatic bit m_hazard();
        logic [31:0] ir;
        int c;
        bit h;
        ir = bus.I_IR;
        c  = cls_of(ir[31:24]);
        if (!bus.I_FE_Valid || m_wait || c == 0) return 1'b0;
        h = busy(int'(ir[19:16]));
        if (c == 1 || c == 4) h = h | busy(int'(ir[15:12]));
        if (c >= 1 && c <= 3) h = h | (m_cnt[ir[23:20]] >= 3);
        return h;
    endfunction

    // One falling-edge step: check dep stall before the edge, advance model, check outputs after
    task automatic cycle();
        logic [31:0] ir;
        int  c, s1, s2, wbi;
        bit  haz, issue;
        @(posedge clk);
        haz = m_hazard();
        if (lock) check("dep_stall", {31'd0, bus.O_DepStallSignal}, {31'd0, haz});
        ir  = bus.I_IR;
        c   = cls_of(ir[31:24]);
        s1  = int'(ir[19:16]);
        s2  = int'(ir[15:12]);
        wbi = int'(bus.I_WBRegIdx);
        e_lock  = lock;
        e_reset = !lock;
        if (!lock) begin
            for (int r = 0; r < 16; r++) begin
                m_rf[r]  = 0;
                m_cnt[r] = 0;
            end
            m_wait = 0;
            e_valid = 0; e_op = 8'hFF; e_pc = 0; e_dest = 0; e_s1 = 0; e_s2 = 0;
        end else begin
            issue = bus.I_FE_Valid && !m_wait && !haz && !bus.I_GPUStallSignal && (c != 0);
            if (!bus.I_GPUStallSignal) begin
                if (issue) begin
                    e_valid = 1;
                    e_op    = int'(ir[31:24]);
                    e_pc    = int'(bus.I_PC);
                    e_dest  = int'(ir[23:20]);
                    e_s1    = (bus.I_WBEnable && wbi == s1) ? int'(bus.I_WBData) : m_rf[s1];
                    if (c == 1 || c == 4)
                        e_s2 = (bus.I_WBEnable && wbi == s2) ? int'(bus.I_WBData) : m_rf[s2];
                    else
                        e_s2 = int'(ir[15:0]);
                    if (c == 5 || c == 6) m_wait = 1;
                end else begin
                    e_valid = 0;
                    e_op    = 8'hFF;
                    if (m_wait && bus.I_BranchAddrSelect) m_wait = 0;
                end
            end
            if (issue && c >= 1 && c <= 3) m_cnt[ir[23:20]]++;
            if (bus.I_WBEnable) begin
                if (m_cnt[wbi] > 0) m_cnt[wbi]--;
                m_rf[wbi] = int'(bus.I_WBData);
            end
        end
        e_bstall = m_wait;
        @(negedge clk);
        #1;
        check("o_lock",   {31'd0, bus.O_LOCK},              {31'd0, e_lock});
        check("de_valid", {31'd0, bus.O_DE_Valid},          {31'd0, e_valid});
        check("opcode",   {24'd0, bus.O_Opcode},            e_op);
        check("br_stall", {31'd0, bus.O_BranchStallSignal}, {31'd0, e_bstall});
        if (e_valid || e_reset) begin
            check("pc",   {16'd0, bus.O_PC},         e_pc);
            check("dest", {28'd0, bus.O_DestRegIdx}, e_dest);
            check("src1", {16'd0, bus.O_Src1Value},  e_s1);
            check("src2", {16'd0, bus.O_Src2Value},  e_s2);
        end
    endtask

    task automatic present(input bit v, input logic [15:0] pc, input logic [31:0] ir);
        bus.I_FE_Valid = v;
        bus.I_PC       = pc;
        bus.I_IR       = ir;
    endtask

    task automatic wb(input bit en, input logic [3:0] idx, input logic [15:0] data);
        bus.I_WBEnable = en;
        bus.I_WBRegIdx = idx;
        bus.I_WBData   = data;
    endtask

    function automatic logic [31:0] mk_rr(input logic [7:0] op, input logic [3:0] d,
                                          input logic [3:0] s1, input logic [3:0] s2);
        return {op, d, s1, s2, 12'h000};
    endfunction

    function automatic logic [31:0] mk_ri(input logic [7:0] op, input logic [3:0] d,
                                          input logic [3:0] s1, input logic [15:0] imm);
        return {op, d, s1, imm};
    endfunction

    logic [7:0] op_pool [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12,
                                 8'h21, 8'h31, 8'h41, 8'h51, 8'hFF, 8'h77};

    initial begin
        lock = 1'b0;
        bus.I_GPUStallSignal   = 1'b0;
        bus.I_BranchAddrSelect = 1'b0;
        present(1'b1, 16'h0099, mk_ri(8'h41, 4'd0, 4'd0, 16'h0001));
        wb(1'b1, 4'd5, 16'hDEAD);

        // Reset held two edges; in-flight fetch and writeback are discarded
        cycle();
        cycle();
        check("rst_opcode", {24'd0, bus.O_Opcode}, 32'h0000_00FF);
        lock = 1'b1;
        wb(1'b0, 4'd0, 16'h0000);
        present(1'b1, 16'h0001, mk_ri(8'h11, 4'd6, 4'd5, 16'h0077));
        cycle();
        check("rst_rf5_zero", {16'd0, bus.O_Src1Value}, 32'h0);
        check("o_lock_high",  {31'd0, bus.O_LOCK},      32'h1);

        // RAW: second ADD waits on r3, issues on the writeback edge via bypass
        present(1'b1, 16'h0010, mk_rr(8'h01, 4'd3, 4'd1, 4'd2));
        cycle();
        present(1'b1, 16'h0011, mk_rr(8'h01, 4'd4, 4'd3, 4'd1));
        #1 check("raw_dep_hi", {31'd0, bus.O_DepStallSignal}, 32'h1);
        cycle();
        cycle();
        wb(1'b1, 4'd3, 16'h0042);
        #1 check("raw_dep_bypass", {31'd0, bus.O_DepStallSignal}, 32'h0);
        cycle();
        check("raw_src1", {16'd0, bus.O_Src1Value}, 32'h0042);
        check("raw_pc",   {16'd0, bus.O_PC},        32'h0011);
        wb(1'b0, 4'd0, 16'h0000);

        // Writeback-only then read-back with an immediate operand
        present(1'b0, 16'h0000, 32'h0);
        wb(1'b1, 4'd7, 16'h1234);
        cycle();
        wb(1'b0, 4'd0, 16'h0000);
        present(1'b1, 16'h0030, mk_ri(8'h11, 4'd8, 4'd7, 16'h5A5A));
        cycle();
        check("wb_src1", {16'd0, bus.O_Src1Value}, 32'h1234);
        check("wb_imm",  {16'd0, bus.O_Src2Value}, 32'h5A5A);

        // Branch: stall from the issue edge until resolution
        present(1'b1, 16'h0020, mk_ri(8'h41, 4'd0, 4'd0, 16'h0004));
        cycle();
        check("br_issue", {31'd0, bus.O_BranchStallSignal}, 32'h1);
        present(1'b1, 16'h0021, mk_rr(8'h01, 4'd10, 4'd0, 4'd0));
        repeat (3) cycle();
        check("br_bubble", {24'd0, bus.O_Opcode}, 32'h0000_00FF);
        bus.I_BranchAddrSelect = 1'b1;
        cycle();
        check("br_released", {31'd0, bus.O_BranchStallSignal}, 32'h0);
        bus.I_BranchAddrSelect = 1'b0;
        cycle();
        check("br_after_pc", {16'd0, bus.O_PC}, 32'h0021);

        // Saturation: three writers to r2 in flight, the fourth waits
        present(1'b1, 16'h0050, mk_ri(8'h12, 4'd2, 4'd0, 16'h0001));
        repeat (3) cycle();
        cycle();
        check("sat_stall_valid", {31'd0, bus.O_DE_Valid}, 32'h0);
        wb(1'b1, 4'd2, 16'h0AAA);
        cycle();
        wb(1'b0, 4'd0, 16'h0000);
        cycle();
        check("sat_issue", {31'd0, bus.O_DE_Valid}, 32'h1);
        #1 check("sat_full_again", {31'd0, bus.O_DepStallSignal}, 32'h1);

        // Reset in the middle of a branch wait
        present(1'b1, 16'h0060, mk_ri(8'h51, 4'd0, 4'd0, 16'h0000));
        cycle();
        lock = 1'b0;
        cycle();
        check("rst_mid_branch", {31'd0, bus.O_BranchStallSignal}, 32'h0);
        lock = 1'b1;

        // GPU stall for three edges with a concurrent writeback to r9
        present(1'b1, 16'h0040, mk_rr(8'h01, 4'd11, 4'd0, 4'd0));
        cycle();
        present(1'b1, 16'h0041, mk_ri(8'h11, 4'd12, 4'd9, 16'h0003));
        bus.I_GPUStallSignal = 1'b1;
        wb(1'b1, 4'd9, 16'hBEEF);
        cycle();
        wb(1'b0, 4'd0, 16'h0000);
        cycle();
        cycle();
        check("gpu_frozen_pc", {16'd0, bus.O_PC}, 32'h0040);
        bus.I_GPUStallSignal = 1'b0;
        cycle();
        check("gpu_release_src1", {16'd0, bus.O_Src1Value}, 32'hBEEF);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ir;
            lock = ($urandom_range(0, 60) != 0);
            ir = $urandom;
            ir[31:24] = op_pool[$urandom_range(0, 11)];
            present(($urandom_range(0, 3) != 0), 16'($urandom), ir);
            bus.I_GPUStallSignal   = ($urandom_range(0, 6) == 0);
            bus.I_BranchAddrSelect = ($urandom_range(0, 2) == 0);
            wb(($urandom_range(0, 4) < 2), 4'($urandom), 16'($urandom));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
